// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder: valid/ready word intake, one-entry hold buffer, one bit per slot.
// Optional even-parity slot after each word when SERIALIZER_PARITY_EN is defined.
module bit_stream_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BIT_PERIOD = 1,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              input_bit,
  output logic              bit_valid,
  output logic              busy,
`ifdef SERIALIZER_PARITY_EN
  output logic              bit_is_parity,
`endif
  output logic [15:0]       words_sent
);

`ifdef SERIALIZER_PARITY_EN
  localparam int unsigned PAR_SLOTS = 1;
`else
  localparam int unsigned PAR_SLOTS = 0;
`endif
  localparam int unsigned SLOTS = DATA_W + PAR_SLOTS;
  localparam int unsigned IDX_W = $clog2(SLOTS);
  localparam int unsigned CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] SLOT_MAX = CNT_W'(BIT_PERIOD - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic                hold_valid;
  logic [DATA_W-1:0]   hold_data;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shifted;
  logic [IDX_W-1:0]    bit_idx;
  logic [CNT_W-1:0]    slot_cnt;
  logic                accept;
  logic                load;
  logic                advance;
  logic                word_done;
  logic                slot_end;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [IDX_W-1:0] PRE_PAR_IDX = IDX_W'(SLOTS - 2);
  logic                par_bit;
`endif

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  assign s_ready  = !hold_valid && !reset;
  assign accept   = s_valid && s_ready;
  assign busy     = hold_valid || (state_q != IDLE);
  assign slot_end = (slot_cnt == '0);
  assign shifted  = MSB_FIRST ? (shreg << 1) : (shreg >> 1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and shifter control strobes
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    advance   = 1'b0;
    word_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (slot_end) begin
          if (bit_idx == LAST_IDX) begin
            word_done = 1'b1;
            if (hold_valid) load    = 1'b1;
            else            state_d = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold buffer: a fresh accept wins over a drain on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= s_data;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // Shifter, slot timer and registered serial outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg      <= '0;
      bit_idx    <= '0;
      slot_cnt   <= '0;
      input_bit  <= 1'b0;
      bit_valid  <= 1'b0;
      words_sent <= '0;
`ifdef SERIALIZER_PARITY_EN
      par_bit       <= 1'b0;
      bit_is_parity <= 1'b0;
`endif
    end else begin
      if (word_done) words_sent <= words_sent + 16'd1;
      if (load) begin
        shreg     <= hold_data;
        bit_idx   <= '0;
        slot_cnt  <= SLOT_MAX;
        input_bit <= first_bit(hold_data);
        bit_valid <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
        par_bit       <= ^hold_data;
        bit_is_parity <= 1'b0;
`endif
      end else if (advance) begin
        shreg    <= shifted;
        bit_idx  <= bit_idx + IDX_W'(1);
        slot_cnt <= SLOT_MAX;
`ifdef SERIALIZER_PARITY_EN
        if (bit_idx == PRE_PAR_IDX) begin
          input_bit     <= par_bit;
          bit_is_parity <= 1'b1;
        end else begin
          input_bit <= first_bit(shifted);
        end
`else
        input_bit <= first_bit(shifted);
`endif
      end else if (word_done) begin
        input_bit <= 1'b0;
        bit_valid <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
        bit_is_parity <= 1'b0;
`endif
      end else if (state_q == SHIFT) begin
        slot_cnt <= slot_cnt - CNT_W'(1);
      end
    end
  end

endmodule
